// File: rtl/ss_marquee.sv
// Scrolling seven-segment message stage: FIFO of decoded patterns shifted into digit 0 on each tick.
// Define MARQUEE_WRAP_EN to rotate the display continuously instead of draining it with blanks.
module ss_marquee #(
  parameter int DIGITS = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    hz100,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [6:0]              in_seg,
  output logic                    in_ready,
  output logic [DIGITS*7-1:0]     disp,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_DRAIN} state_t;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_BLANK, OP_ROT} op_t;

  state_t              r_state;
  state_t              w_state_nxt;
  op_t                 w_op;
  logic [6:0]          r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [DIGITS*7-1:0] r_disp;
  logic [DW-1:0]       r_drain;
  logic [DW-1:0]       w_drain_nxt;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [6:0]          w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign in_ready = !w_full && !clear;
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rd_ptr];

  assign disp  = r_disp;
  assign count = r_count;
`ifdef MARQUEE_WRAP_EN
  assign busy = !w_empty;
`else
  assign busy = (r_state != S_IDLE) || !w_empty;
`endif

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset)      r_state <= S_IDLE;
    else if (clear) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (tick) begin
      case (r_state)
        S_IDLE:   if (!w_empty) w_state_nxt = S_SCROLL;
`ifdef MARQUEE_WRAP_EN
        S_SCROLL: if (w_empty) w_state_nxt = S_IDLE;
`else
        S_SCROLL: if (w_empty) w_state_nxt = S_DRAIN;
        // The tick that takes the counter to zero is the one that clears the last digit.
        S_DRAIN: begin
          if (!w_empty)                  w_state_nxt = S_SCROLL;
          else if (r_drain <= DW'(1))    w_state_nxt = S_IDLE;
        end
`endif
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_op        = OP_HOLD;
    w_pop       = 1'b0;
    w_drain_nxt = r_drain;
    if (tick && !clear) begin
      if (!w_empty) begin
        w_op  = OP_LOAD;
        w_pop = 1'b1;
      end else begin
        case (r_state)
`ifdef MARQUEE_WRAP_EN
          S_IDLE, S_SCROLL: w_op = OP_ROT;
`else
          S_SCROLL: begin
            w_op        = OP_BLANK;
            w_drain_nxt = DW'(DIGITS - 1);
          end
          S_DRAIN: begin
            w_op        = OP_BLANK;
            w_drain_nxt = (r_drain != '0) ? r_drain - DW'(1) : '0;
          end
`endif
          default: w_op = OP_HOLD;
        endcase
      end
    end
  end

  // Pattern storage carries no reset; only pointers and occupancy are control.
  always_ff @(posedge hz100) begin
    if (w_push) r_mem[r_wr_ptr] <= in_seg;
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drain  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drain  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_drain <= w_drain_nxt;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset)      r_disp <= '0;
    else if (clear) r_disp <= '0;
    else begin
      case (w_op)
        OP_LOAD:  r_disp <= {r_disp[DIGITS*7-8:0], w_head};
        OP_BLANK: r_disp <= {r_disp[DIGITS*7-8:0], 7'b0};
        OP_ROT:   r_disp <= {r_disp[DIGITS*7-8:0], r_disp[DIGITS*7-1 -: 7]};
        default:  r_disp <= r_disp;
      endcase
    end
  end

endmodule
